// File: rtl/block_stats_pkg.sv
// Shared types and width helpers for the block statistics engine.
//
// Contents:
//   state_e : top-level FSM states (ACCUM, FINAL)
//   SUM_W   : per-channel sum accumulator width, DW + L
//   SQ_W    : per-channel sum-of-squares accumulator width, 2*DW + L
//   ch_lsb  : LSB position of channel k inside a packed multi-channel bus
package block_stats_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FINAL = 1'b1
    } state_e;

    function automatic int SUM_W(input int dw, input int l);
        return dw + l;
    endfunction

    function automatic int SQ_W(input int dw, input int l);
        return 2 * dw + l;
    endfunction

    function automatic int ch_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/block_stats_calc.sv
// Combinational mean / population-variance evaluation for one channel.
// Shared by all channels; the top presents one channel per FINAL cycle.
//
// Ports:
//   sum_i    : sum of the N samples of the block
//   sumsq_i  : sum of squares of the N samples
//   mean_o   : floor(sum / N)
//   var_o    : (sumsq - ((sum*sum) >> L)) >> L, truncating
module block_stats_calc
    import block_stats_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LOG2_SAMPLES = 6
)
(
    input  logic [SUM_W(DATA_WIDTH, LOG2_SAMPLES)-1:0] sum_i,
    input  logic [SQ_W(DATA_WIDTH, LOG2_SAMPLES)-1:0]  sumsq_i,
    output logic [DATA_WIDTH-1:0]                      mean_o,
    output logic [2*DATA_WIDTH-1:0]                    var_o
);

    localparam int SW  = SUM_W(DATA_WIDTH, LOG2_SAMPLES);
    localparam int QW  = SQ_W(DATA_WIDTH, LOG2_SAMPLES);
    localparam int PSW = 2 * SW;
    localparam int VW  = 2 * DATA_WIDTH;

    logic [PSW-1:0] sum_sq;
    logic [QW-1:0]  inner;
    logic [QW-1:0]  diff;

    assign sum_sq = PSW'(sum_i) * PSW'(sum_i);
    // (sum^2)/N is bounded by sumsq (Cauchy-Schwarz), so it fits QW bits
    // and the subtraction below cannot wrap.
    assign inner  = QW'(sum_sq >> LOG2_SAMPLES);
    assign diff   = sumsq_i - inner;

    assign mean_o = DATA_WIDTH'(sum_i >> LOG2_SAMPLES);
    assign var_o  = VW'(diff >> LOG2_SAMPLES);

endmodule

// File: rtl/block_stats_unit.sv
// Streaming per-block statistics engine. Accumulates sum and sum of
// squares for NUM_CH channels over N = 2^LOG2_SAMPLES accepted beats, then
// spends NUM_CH cycles computing mean and population variance per channel
// through one shared calc unit.
//
// Optional feature (macro BLOCK_STATS_MINMAX_EN): adds min_out / max_out,
// per-channel running min/max of the block, valid alongside out_valid.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   soft_clr            : synchronous abort of the current block and result
//   in_valid/in_ready   : input handshake, in_data holds NUM_CH samples
//   out_valid/out_ready : result handshake
//   mean_out, var_out   : per-channel results, channel k in slice k
//   busy                : high while the FINAL computation runs
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting beats; last beat of a block waits for a free result slot
// FINAL | one channel per cycle through the calc unit, input stalled
module block_stats_unit
    import block_stats_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CH       = 3,
    parameter int LOG2_SAMPLES = 6
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           soft_clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0]   mean_out,
    output logic [NUM_CH*2*DATA_WIDTH-1:0] var_out,
`ifdef BLOCK_STATS_MINMAX_EN
    output logic [NUM_CH*DATA_WIDTH-1:0]   min_out,
    output logic [NUM_CH*DATA_WIDTH-1:0]   max_out,
`endif
    output logic                           busy
);

    localparam int SW = SUM_W(DATA_WIDTH, LOG2_SAMPLES);
    localparam int QW = SQ_W(DATA_WIDTH, LOG2_SAMPLES);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;
    localparam logic [CW-1:0]           CH_LAST  = CW'(NUM_CH - 1);

    state_e                               state_q;
    logic [LOG2_SAMPLES-1:0]              count_q;
    logic [CW-1:0]                        ch_idx_q;
    logic [SW-1:0]                        sum_q   [NUM_CH];
    logic [QW-1:0]                        sumsq_q [NUM_CH];
    logic [SW-1:0]                        sum_d   [NUM_CH];
    logic [QW-1:0]                        sumsq_d [NUM_CH];
    logic [DATA_WIDTH-1:0]                x       [NUM_CH];
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    mean_q;
    logic [NUM_CH-1:0][PW-1:0]            var_q;
    logic                                 out_valid_q;

    logic                                 last_beat;
    logic                                 accept;
    logic                                 pop;

    logic [SW-1:0]                        calc_sum;
    logic [QW-1:0]                        calc_sumsq;
    logic [DATA_WIDTH-1:0]                calc_mean;
    logic [PW-1:0]                        calc_var;

`ifdef BLOCK_STATS_MINMAX_EN
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    min_q,  max_q;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    min_d,  max_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    min_out_q, max_out_q;

    assign min_out = min_out_q;
    assign max_out = max_out_q;
`endif

    // The last beat of a block may only land if the result slot is free by
    // the time FINAL finishes; a same-cycle pop counts as free.
    assign last_beat = (count_q == CNT_LAST);
    assign in_ready  = (state_q == ACCUM) && !(last_beat && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign mean_out  = mean_q;
    assign var_out   = var_q;
    assign busy      = (state_q == FINAL);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            x[k]       = in_data[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
            sum_d[k]   = sum_q[k] + SW'(x[k]);
            sumsq_d[k] = sumsq_q[k] + QW'(PW'(x[k]) * PW'(x[k]));
`ifdef BLOCK_STATS_MINMAX_EN
            min_d[k]   = (x[k] < min_q[k]) ? x[k] : min_q[k];
            max_d[k]   = (x[k] > max_q[k]) ? x[k] : max_q[k];
`endif
        end
    end

    assign calc_sum   = sum_q[ch_idx_q];
    assign calc_sumsq = sumsq_q[ch_idx_q];

    block_stats_calc #(
        .DATA_WIDTH   (DATA_WIDTH),
        .LOG2_SAMPLES (LOG2_SAMPLES)
    ) u_calc (
        .sum_i   (calc_sum),
        .sumsq_i (calc_sumsq),
        .mean_o  (calc_mean),
        .var_o   (calc_var)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
            mean_q      <= '0;
            var_q       <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k]   <= '0;
                sumsq_q[k] <= '0;
            end
`ifdef BLOCK_STATS_MINMAX_EN
            min_q     <= '1;
            max_q     <= '0;
            min_out_q <= '0;
            max_out_q <= '0;
`endif
        end else if (soft_clr) begin
            // Results keep their last values; only the handshake is dropped.
            state_q     <= ACCUM;
            count_q     <= '0;
            ch_idx_q    <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                sum_q[k]   <= '0;
                sumsq_q[k] <= '0;
            end
`ifdef BLOCK_STATS_MINMAX_EN
            min_q <= '1;
            max_q <= '0;
`endif
        end else begin
            if (pop) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        count_q <= count_q + LOG2_SAMPLES'(1);
                        for (int k = 0; k < NUM_CH; k++) begin
                            sum_q[k]   <= sum_d[k];
                            sumsq_q[k] <= sumsq_d[k];
                        end
`ifdef BLOCK_STATS_MINMAX_EN
                        if (last_beat) begin
                            min_out_q <= min_d;
                            max_out_q <= max_d;
                            min_q     <= '1;
                            max_q     <= '0;
                        end else begin
                            min_q <= min_d;
                            max_q <= max_d;
                        end
`endif
                        if (last_beat) begin
                            state_q  <= FINAL;
                            ch_idx_q <= '0;
                        end
                    end
                end
                FINAL: begin
                    mean_q[ch_idx_q]  <= calc_mean;
                    var_q[ch_idx_q]   <= calc_var;
                    sum_q[ch_idx_q]   <= '0;
                    sumsq_q[ch_idx_q] <= '0;
                    if (ch_idx_q == CH_LAST) begin
                        state_q     <= ACCUM;
                        ch_idx_q    <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        ch_idx_q <= ch_idx_q + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_stats_unit.sv
// Self-checking bench for block_stats_unit. A behavioural model computes
// each block's mean/variance (and min/max when BLOCK_STATS_MINMAX_EN is
// defined) from the accepted beats with plain integer arithmetic and pushes
// the expectation into a queue; a monitor pops it whenever a result is taken.
module tb_block_stats_unit;

    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int L   = 6;
    localparam int N   = 1 << L;
    localparam int BW  = NCH * DW;
    localparam int VW  = 2 * DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            soft_clr;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BW-1:0]   mean_out;
    logic [2*BW-1:0] var_out;
    logic            busy;
`ifdef BLOCK_STATS_MINMAX_EN
    logic [BW-1:0]   min_out;
    logic [BW-1:0]   max_out;
`endif

    logic rdy_fixed;
    logic rdy_rand;
    logic rnd_bit = 1'b0;

    assign out_ready = rdy_rand ? rnd_bit : rdy_fixed;

    always #5 clk = ~clk;
    always @(negedge clk) rnd_bit = ($urandom_range(0, 1) == 1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    block_stats_unit #(
        .DATA_WIDTH   (DW),
        .NUM_CH       (NCH),
        .LOG2_SAMPLES (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_clr  (soft_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mean_out  (mean_out),
        .var_out   (var_out),
`ifdef BLOCK_STATS_MINMAX_EN
        .min_out   (min_out),
        .max_out   (max_out),
`endif
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [BW-1:0]   mean;
        logic [2*BW-1:0] vr;
        logic [BW-1:0]   mn;
        logic [BW-1:0]   mx;
    } exp_t;

    exp_t   exp_q[$];
    longint m_sum [NCH];
    longint m_sq  [NCH];
    int     m_min [NCH];
    int     m_max [NCH];
    int     m_cnt;

    logic [BW-1:0]   last_mean = '0;
    logic [2*BW-1:0] last_var  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_sum[k] = 0;
            m_sq[k]  = 0;
            m_min[k] = (1 << DW) - 1;
            m_max[k] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_accept(input logic [BW-1:0] d);
        exp_t   e;
        longint v;
        for (int k = 0; k < NCH; k++) begin
            v = longint'(d[k*DW +: DW]);
            m_sum[k] += v;
            m_sq[k]  += v * v;
            if (int'(v) < m_min[k]) m_min[k] = int'(v);
            if (int'(v) > m_max[k]) m_max[k] = int'(v);
        end
        m_cnt++;
        if (m_cnt == N) begin
            for (int k = 0; k < NCH; k++) begin
                e.mean[k*DW +: DW] = DW'(m_sum[k] / N);
                e.vr[k*VW +: VW]   = VW'((m_sq[k] - (m_sum[k] * m_sum[k]) / N) / N);
                e.mn[k*DW +: DW]   = DW'(m_min[k]);
                e.mx[k*DW +: DW]   = DW'(m_max[k]);
            end
            exp_q.push_back(e);
            model_clear();
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [BW-1:0] d);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_data  = d;
        #4;
        while (!in_ready) begin
            waitc++;
            if (waitc > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waitc);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #4;
        end
        @(negedge clk);
        in_valid = 1'b0;
        model_accept(d);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_out_valid();
        int i;
        for (i = 0; i < 50; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin : monitor
        logic            hold_v;
        logic [BW-1:0]   hm;
        logic [2*BW-1:0] hv;
        exp_t            e;
        hold_v = 1'b0;
        hm     = '0;
        hv     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || !out_valid) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_mean", 64'(mean_out), 64'(hm));
                    check("hold_var",  64'(var_out),  64'(hv));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: mean %0h var %0h, expected no result", mean_out, var_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("mean", 64'(mean_out), 64'(e.mean));
                        check("var",  64'(var_out),  64'(e.vr));
`ifdef BLOCK_STATS_MINMAX_EN
                        check("min",  64'(min_out),  64'(e.mn));
                        check("max",  64'(max_out),  64'(e.mx));
`endif
                        last_mean = mean_out;
                        last_var  = var_out;
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hm     = mean_out;
                    hv     = var_out;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [BW-1:0] d;
        int            c0;

        rst_n     = 1'b0;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rdy_fixed = 1'b1;
        rdy_rand  = 1'b0;
        model_clear();

        #12;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mean",      64'(mean_out),  64'd0);
        check("rst_var",       64'(var_out),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant block, with latency and FINAL-phase flags.
        for (int i = 0; i < N; i++) send_beat({NCH{DW'(100)}});
        c0 = cyc;
        check("final_busy",     64'(busy),     64'd1);
        check("final_in_ready", 64'(in_ready), 64'd0);
        wait_out_valid();
        check("latency", 64'(cyc - c0), 64'(NCH));
        drain();

        // Alternating / ramp / saturated channels.
        for (int i = 0; i < N; i++) begin
            d = {DW'(255), DW'(i), ((i % 2) == 1) ? DW'(255) : DW'(0)};
            send_beat(d);
        end
        drain();

        // Back-pressure: last beat of block 2 stalls until block 1 is taken.
        rdy_fixed = 1'b0;
        for (int i = 0; i < N; i++) send_beat(BW'($urandom));
        wait_out_valid();
        for (int i = 0; i < N - 1; i++) send_beat(BW'($urandom));
        d        = BW'($urandom);
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 3; c++) begin
            #4;
            check("stall_in_ready",  64'(in_ready),  64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        rdy_fixed = 1'b1;
        #4;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        model_accept(d);
        drain();

        // soft_clr after a partial block; the beat presented with it is dropped.
        for (int i = 0; i < 30; i++) send_beat(BW'($urandom));
        soft_clr = 1'b1;
        in_valid = 1'b1;
        in_data  = BW'($urandom);
        @(negedge clk);
        soft_clr = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_mean_kept", 64'(mean_out),  64'(last_mean));
        check("clr_var_kept",  64'(var_out),   64'(last_var));
        for (int i = 0; i < N; i++) send_beat({NCH{DW'(7)}});
        drain();

        // Asynchronous reset during FINAL loses the block.
        for (int i = 0; i < N; i++) send_beat(BW'($urandom));
        check("pre_rst_busy", 64'(busy), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_mean",      64'(mean_out),  64'd0);
        check("arst_var",       64'(var_out),   64'd0);
        check("arst_busy",      64'(busy),      64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) send_beat({NCH{DW'(50)}});
        drain();

        // Random blocks with input gaps and random consumer back-pressure.
        rdy_rand = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < N; i++) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                send_beat(BW'($urandom));
            end
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
